// File: rtl/line_frame_receiver_if.sv
// rtl/line_frame_receiver_if.sv - word delivery channel between line_frame_receiver and its consumer
//
// One-entry valid/ready word channel.
//   data_o  : received word, receiver -> consumer
//   valid_o : data_o holds an unconsumed word, receiver -> consumer
//   ready_i : consumer accepts the word when valid_o && ready_i, consumer -> receiver
// Modports: master = receiver side, slave = consumer side.
interface line_frame_receiver_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              ready_i;

   modport master (output data_o, output valid_o, input ready_i);
   modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/line_frame_receiver.sv
// rtl/line_frame_receiver.sv - serial start/data/parity/stop frame receiver with one-entry holding register
//
// Samples line_i once per bit at the bit centre and recovers frames, LSB first.
// Optional feature macro: LINE_RX_PARITY_EN (adds an even-parity bit after the data bits).
//   clk          : clock, rising edge
//   reset        : synchronous, active-high
//   line_i       : serial line, idle high, already in the clk domain
//   rx           : word channel (master modport): data_o, valid_o out, ready_i in
//   frame_err_o  : one-cycle pulse, stop bit sampled low
//   parity_err_o : one-cycle pulse, parity mismatch (constant 0 without parity)
//   overrun_o    : one-cycle pulse, good frame dropped because the holding register was full
//   busy_o       : receiver FSM is not idle
module line_frame_receiver #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  line_i,
   line_frame_receiver_if.master rx,
   output logic                  frame_err_o,
   output logic                  parity_err_o,
   output logic                  overrun_o,
   output logic                  busy_o
);
   localparam int H  = BIT_CYCLES / 2;
   localparam int CW = $clog2(BIT_CYCLES + 1);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // cyc_cnt holds the number of cycles since the previous sample point
   // (or since the start detection while in START).
   localparam logic [CW-1:0] START_SAMPLE = CW'(H - 1);
   localparam logic [CW-1:0] BIT_SAMPLE   = CW'(BIT_CYCLES);
   localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t            state;
   logic [CW-1:0]     cyc_cnt;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
`ifdef LINE_RX_PARITY_EN
   logic              par_bad;
   logic              parity_err_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         cyc_cnt      <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
`ifdef LINE_RX_PARITY_EN
         par_bad      <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
`ifdef LINE_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         // A pop empties the holding register; a load in STOP overrides this.
         if (valid_q && rx.ready_i) begin
            valid_q <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (!line_i) begin
                  state   <= S_START;
                  cyc_cnt <= CW'(1);
                  bit_cnt <= '0;
               end
            end

            S_START: begin
               if (cyc_cnt == START_SAMPLE) begin
                  cyc_cnt <= CW'(1);
                  // A line that is high again at mid start bit was a glitch.
                  state   <= line_i ? S_IDLE : S_DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end

            S_DATA: begin
               if (cyc_cnt == BIT_SAMPLE) begin
                  cyc_cnt <= CW'(1);
                  // Shift right so that after DATA_W samples bit k sits at position k.
                  shreg   <= (shreg >> 1) | (DATA_W'(line_i) << (DATA_W - 1));
                  if (bit_cnt == LAST_BIT) begin
`ifdef LINE_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end

`ifdef LINE_RX_PARITY_EN
            S_PARITY: begin
               if (cyc_cnt == BIT_SAMPLE) begin
                  cyc_cnt <= CW'(1);
                  // Even parity: data bits plus parity bit must xor to 0.
                  par_bad <= ^{shreg, line_i};
                  state   <= S_STOP;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
`endif

            S_STOP: begin
               if (cyc_cnt == BIT_SAMPLE) begin
                  if (!line_i) begin
                     frame_err_o <= 1'b1;
                     state       <= S_WAIT_HIGH;
                  end
`ifdef LINE_RX_PARITY_EN
                  else if (par_bad) begin
                     parity_err_q <= 1'b1;
                     state        <= S_IDLE;
                  end
`endif
                  else begin
                     // Free or being popped this cycle: the new word replaces it.
                     if (!valid_q || rx.ready_i) begin
                        data_q  <= shreg;
                        valid_q <= 1'b1;
                     end else begin
                        overrun_o <= 1'b1;
                     end
                     state <= S_IDLE;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end

            // A held-low line (break) must return high before a new start is accepted.
            S_WAIT_HIGH: begin
               if (line_i) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign rx.data_o  = data_q;
   assign rx.valid_o = valid_q;
   assign busy_o     = (state != S_IDLE);
`ifdef LINE_RX_PARITY_EN
   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_line_frame_receiver.sv
// tb/tb_line_frame_receiver.sv - scoreboard testbench for line_frame_receiver
module tb_line_frame_receiver;
   localparam int DW = 8;
   localparam int BC = 4;
   localparam int H  = BC / 2;
`ifdef LINE_RX_PARITY_EN
   localparam int P  = 1;
`else
   localparam int P  = 0;
`endif
   // Edge index of the stop sample relative to the start-detection edge.
   localparam int STOP_OFF = H - 1 + (DW + 1 + P) * BC;

   localparam int K_GOOD = 0;
   localparam int K_FERR = 1;
   localparam int K_PERR = 2;
   localparam int K_OVR  = 3;

   typedef struct {
      int            stop;
      int            kind;
      logic [DW-1:0] data;
   } frame_t;

   typedef struct {
      int cyc;
      int kind;
   } ev_t;

   logic clk;
   logic reset;
   logic line_i;
   logic frame_err_o;
   logic parity_err_o;
   logic overrun_o;
   logic busy_o;

   line_frame_receiver_if #(.DATA_W(DW)) rx_if ();

   line_frame_receiver #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
      .clk          (clk),
      .reset        (reset),
      .line_i       (line_i),
      .rx           (rx_if),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o),
      .overrun_o    (overrun_o),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            cyc = 0;
   int            nchecks = 0;
   int            nerrs = 0;
   bit            mon_en = 1'b0;
   bit            mvalid = 1'b0;
   int            rmode = 0;
   frame_t        pend[$];
   ev_t           err_q[$];
   logic [DW-1:0] data_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: frame outcomes resolved at the stop-sample edge.
   always @(posedge clk) begin : model
      frame_t f;
      ev_t    e;
      bit     pop;
      if (reset) begin
         mvalid = 1'b0;
         data_q.delete();
         pend.delete();
      end else begin
         pop = mvalid && rx_if.ready_i;
         if (pend.size() > 0 && pend[0].stop == cyc + 1) begin
            f = pend.pop_front();
            if (f.kind == K_GOOD) begin
               if (!mvalid || rx_if.ready_i) begin
                  data_q.push_back(f.data);
                  mvalid = 1'b1;
               end else begin
                  e.cyc  = cyc + 1;
                  e.kind = K_OVR;
                  err_q.push_back(e);
               end
            end else begin
               e.cyc  = cyc + 1;
               e.kind = f.kind;
               err_q.push_back(e);
               if (pop) mvalid = 1'b0;
            end
         end else if (pop) begin
            mvalid = 1'b0;
         end
      end
   end

   task automatic take_err(input int kind);
      ev_t e;
      if (err_q.size() == 0) begin
         check("unexpected_pulse", kind, 32'hffff_ffff);
      end else begin
         e = err_q.pop_front();
         check("err_kind", kind, e.kind);
         check("err_cycle", cyc, e.cyc);
      end
   endtask

   // Monitor: compares every cycle the DUT presents something.
   always @(negedge clk) begin
      if (mon_en) begin
         check("valid", rx_if.valid_o, mvalid);
         if (rx_if.valid_o) begin
            if (data_q.size() == 0) begin
               check("word_unexpected", data_q.size(), 1);
            end else begin
               check("data", rx_if.data_o, data_q[0]);
               if (rx_if.ready_i) void'(data_q.pop_front());
            end
         end
         while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
            check("err_missed", cyc, err_q[0].cyc);
            void'(err_q.pop_front());
         end
         if (frame_err_o)  take_err(K_FERR);
         if (parity_err_o) take_err(K_PERR);
         if (overrun_o)    take_err(K_OVR);
      end
   end

   // Consumer: 0 = always ready, 1 = stalled, 2 = random.
   initial begin
      rx_if.ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       rx_if.ready_i = 1'b1;
            1:       rx_if.ready_i = 1'b0;
            default: rx_if.ready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      line_i = 1'b1;
      repeat (n) step();
   endtask

   // Drives one frame; abort_at >= 0 pulses reset on that cycle of the frame and stops.
   task automatic send_frame(input logic [DW-1:0] d, input bit stop_bit, input bit par_good,
                             input int abort_at);
      logic   bits[$];
      frame_t f;
      bit     perr;
      bits.push_back(1'b0);
      for (int k = 0; k < DW; k++) bits.push_back(d[k]);
`ifdef LINE_RX_PARITY_EN
      bits.push_back((^d) ^ !par_good);
      perr = !par_good;
`else
      perr = 1'b0;
`endif
      bits.push_back(stop_bit);
      if (abort_at < 0) begin
         f.stop = cyc + 1 + STOP_OFF;
         f.kind = !stop_bit ? K_FERR : (perr ? K_PERR : K_GOOD);
         f.data = d;
         pend.push_back(f);
      end
      for (int i = 0; i < int'(bits.size()) * BC; i++) begin
         line_i = bits[i / BC];
         reset  = (i == abort_at);
         step();
         if (i == abort_at) begin
            reset  = 1'b0;
            line_i = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, rx_if.valid_o, 0);
      check({tag, "_data"},  rx_if.data_o, 0);
      check({tag, "_busy"},  busy_o, 0);
      check({tag, "_ferr"},  frame_err_o, 0);
      check({tag, "_perr"},  parity_err_o, 0);
      check({tag, "_ovr"},   overrun_o, 0);
   endtask

   initial begin
      int            t0;
      int            gap;
      bit            sb;
      bit            pg;
      logic [DW-1:0] d;

      reset  = 1'b1;
      line_i = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      check_all_zero("reset");
      mon_en = 1'b1;

      // Single word, consumer always ready.
      rmode = 0;
      idle(2);
      send_frame(8'hA5, 1'b1, 1'b1, -1);
      idle(4);

      // Stalled consumer: second back-to-back frame overruns.
      rmode = 1;
      send_frame(8'h3C, 1'b1, 1'b1, -1);
      send_frame(8'hC3, 1'b1, 1'b1, -1);
      idle(10);
      rmode = 0;
      idle(4);

      // Framing error followed by a held-low break, then a good frame.
      send_frame(8'h55, 1'b0, 1'b1, -1);
      line_i = 1'b0;
      repeat (20) step();
      idle(2);
      send_frame(8'h96, 1'b1, 1'b1, -1);
      idle(4);

      // One-cycle glitch at idle.
      t0 = cyc + 1;
      line_i = 1'b0;
      step();
      line_i = 1'b1;
      check("glitch_busy_c1", busy_o, 1);
      step();
      check("glitch_busy_c2", busy_o, 0);
      check("glitch_cycle", cyc, t0 + 1);
      idle(4);

`ifdef LINE_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, -1);
      idle(3);
      send_frame(8'h07, 1'b1, 1'b1, -1);
      idle(3);
`endif

      // Reset mid-frame with a word held: everything clears, next frame decodes.
      rmode = 1;
      send_frame(8'h11, 1'b1, 1'b1, -1);
      idle(2);
      send_frame(8'h22, 1'b1, 1'b1, 20);
      check_all_zero("midreset");
      rmode = 0;
      idle(9);
      send_frame(8'h5A, 1'b1, 1'b1, -1);
      idle(4);

      // Randomized frames, random consumer stalls.
      rmode = 2;
      for (int n = 0; n < 40; n++) begin
         d  = DW'($urandom);
         sb = ($urandom_range(0, 7) != 0);
`ifdef LINE_RX_PARITY_EN
         pg = ($urandom_range(0, 7) != 0);
`else
         pg = 1'b1;
`endif
         send_frame(d, sb, pg, -1);
         gap = $urandom_range(0, 5);
         if (!sb && gap == 0) gap = 1;
         idle(gap);
         if ($urandom_range(0, 9) == 0) begin
            line_i = 1'b0;
            step();
            idle(4);
         end
      end

      rmode = 0;
      idle(80);
      check("pending_frames", pend.size(), 0);
      check("pending_errors", err_q.size(), 0);
      check("pending_words", data_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
      $finish;
   end
endmodule
